// File: rtl/fetch_ifid_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register for the 5-stage ARM pipeline.
// The PC drives instruction memory combinationally, and each normal fetch latches the
// instruction and its PC into IF/ID. Fetch honours load-use stalls, branch redirects from
// EX, and a HALT encoding that freezes fetch until the next taken branch.
//
// Ports:
//   clk          clock; all state updates on posedge
//   rst          synchronous, active-low reset
//   stall        hold PC and IF/ID
//   br_taken     redirect from EX; overrides stall
//   br_target    redirect destination PC
//   imem_addr    instruction memory address (= pc)
//   imem_rdata   instruction at imem_addr, valid in the same cycle
//   ifid_pc      PC of the instruction held in IF/ID
//   ifid_instr   instruction held in IF/ID (0 for a bubble)
//   ifid_valid   IF/ID holds a real instruction
//   opcode       ifid_instr[31:21], or 0 for a bubble
//   halted       fetch stopped on the HALT encoding
//   fetch_count  number of instructions latched valid into IF/ID (wraps)
module fetch_ifid_stage #(
  parameter int unsigned        ADDR_W   = 64,
  parameter int unsigned        INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                br_taken,
  input  logic [ADDR_W-1:0]   br_target,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic [ADDR_W-1:0]   ifid_pc,
  output logic [INSTR_W-1:0]  ifid_instr,
  output logic                ifid_valid,
  output logic [10:0]         opcode,
  output logic                halted,
  output logic [31:0]         fetch_count
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  localparam logic [10:0] HaltOpcode = 11'h7FF;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ADDR_W-1:0]    ifid_pc_q, ifid_pc_d;
  logic [INSTR_W-1:0]   ifid_instr_q, ifid_instr_d;
  logic                 ifid_valid_q, ifid_valid_d;
  logic [31:0]          fetch_count_q, fetch_count_d;

  logic                 is_halt_word;

  assign is_halt_word = (imem_rdata[INSTR_W-1 -: 11] == HaltOpcode);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      ifid_pc_q     <= '0;
      ifid_instr_q  <= '0;
      ifid_valid_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_valid_q  <= ifid_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_valid_d  = ifid_valid_q;
    fetch_count_d = fetch_count_q;

    unique case (state_q)
      // Nothing can be in flight yet, so a redirect here is meaningless.
      StBoot: state_d = StRun;

      StRun: begin
        if (br_taken) begin
          // Squash the wrong-path instruction currently in IF.
          pc_d         = br_target;
          ifid_pc_d    = '0;
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
        end else if (!stall) begin
          if (is_halt_word) begin
            // HALT itself never enters the pipe; PC stays on it.
            ifid_pc_d    = '0;
            ifid_instr_d = '0;
            ifid_valid_d = 1'b0;
            state_d      = StHalt;
          end else begin
            ifid_pc_d     = pc_q;
            ifid_instr_d  = imem_rdata;
            ifid_valid_d  = 1'b1;
            pc_d          = pc_q + ADDR_W'(4);
            fetch_count_d = fetch_count_q + 32'd1;
          end
        end
      end

      StHalt: begin
        if (br_taken) begin
          pc_d    = br_target;
          state_d = StRun;
        end
      end

      default: state_d = StBoot;
    endcase
  end

  assign imem_addr   = pc_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_valid  = ifid_valid_q;
  assign opcode      = ifid_valid_q ? ifid_instr_q[INSTR_W-1 -: 11] : 11'b0;
  assign halted      = (state_q == StHalt);
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
module tb_fetch_ifid_stage;

  logic        clk = 1'b0;
  logic        rst, stall, br_taken;
  logic [63:0] br_target;
  logic [63:0] imem_addr, ifid_pc;
  logic [31:0] imem_rdata, ifid_instr, fetch_count;
  logic        ifid_valid, halted;
  logic [10:0] opcode;

  // Second instance for the PC wrap-around case.
  logic        rst_w;
  logic [63:0] imem_addr_w, ifid_pc_w;
  logic [31:0] imem_rdata_w, ifid_instr_w, fetch_count_w;
  logic        ifid_valid_w, halted_w;
  logic [10:0] opcode_w;

  logic [63:0] ovr_addr = 64'h1;
  logic [31:0] ovr_data = 32'h0;

  int checks = 0;
  int errors = 0;

  // Reference model of the architecturally visible state.
  logic [63:0] m_pc, m_ifid_pc;
  logic [31:0] m_instr, m_count;
  logic        m_valid, m_halt, m_boot;

  always #5 clk = ~clk;

  // Deterministic memory image. Addresses 0x1000..0xFFFF occasionally hold HALT;
  // everywhere else the HALT encoding never appears.
  function automatic logic [31:0] hash_word(input logic [63:0] a);
    logic [31:0] w;
    w = a[31:0] * 32'h9E3779B1 + a[63:32] + 32'h7F4A7C15;
    if (a >= 64'h1000 && a < 64'h10000 && w[4:0] == 5'd0) w[31:21] = 11'h7FF;
    else if (w[31:21] == 11'h7FF) w[31] = 1'b0;
    return w;
  endfunction

  assign imem_rdata   = (imem_addr == ovr_addr) ? ovr_data : hash_word(imem_addr);
  assign imem_rdata_w = hash_word(imem_addr_w);

  fetch_ifid_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .ifid_pc    (ifid_pc),
    .ifid_instr (ifid_instr),
    .ifid_valid (ifid_valid),
    .opcode     (opcode),
    .halted     (halted),
    .fetch_count(fetch_count)
  );

  fetch_ifid_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
    .clk        (clk),
    .rst        (rst_w),
    .stall      (1'b0),
    .br_taken   (1'b0),
    .br_target  (64'h0),
    .imem_addr  (imem_addr_w),
    .imem_rdata (imem_rdata_w),
    .ifid_pc    (ifid_pc_w),
    .ifid_instr (ifid_instr_w),
    .ifid_valid (ifid_valid_w),
    .opcode     (opcode_w),
    .halted     (halted_w),
    .fetch_count(fetch_count_w)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("imem_addr", imem_addr, m_pc);
    chk("ifid_pc", ifid_pc, m_ifid_pc);
    chk("ifid_instr", {32'h0, ifid_instr}, {32'h0, m_instr});
    chk("ifid_valid", {63'h0, ifid_valid}, {63'h0, m_valid});
    chk("opcode", {53'h0, opcode}, m_valid ? {53'h0, m_instr[31:21]} : 64'h0);
    chk("halted", {63'h0, halted}, {63'h0, m_halt});
    chk("fetch_count", {32'h0, fetch_count}, {32'h0, m_count});
  endtask

  // Apply one cycle of inputs, advance the model by the fetch rules, then compare.
  task automatic cycle(input bit r, input bit s, input bit b, input logic [63:0] t);
    logic [31:0] word;
    rst = r; stall = s; br_taken = b; br_target = t;
    word = (m_pc == ovr_addr) ? ovr_data : hash_word(m_pc);
    if (!r) begin
      m_pc = 64'h0; m_ifid_pc = 64'h0; m_instr = 32'h0; m_valid = 1'b0;
      m_count = 32'h0; m_halt = 1'b0; m_boot = 1'b1;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (b) begin
      m_pc = t; m_ifid_pc = 64'h0; m_instr = 32'h0; m_valid = 1'b0; m_halt = 1'b0;
    end else if (m_halt || s) begin
      // fetch frozen
    end else if (word[31:21] == 11'h7FF) begin
      m_ifid_pc = 64'h0; m_instr = 32'h0; m_valid = 1'b0; m_halt = 1'b1;
    end else begin
      m_ifid_pc = m_pc; m_instr = word; m_valid = 1'b1;
      m_pc = m_pc + 64'd4; m_count = m_count + 32'd1;
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 64'h0; rst_w = 1'b0;
    m_pc = 64'h0; m_ifid_pc = 64'h0; m_instr = 32'h0; m_valid = 1'b0;
    m_count = 32'h0; m_halt = 1'b0; m_boot = 1'b1;

    // Reset, boot bubble, then three sequential fetches.
    cycle(0, 0, 0, 0);
    cycle(0, 1, 1, 64'h80);
    cycle(1, 0, 1, 64'h80);
    chk("boot_valid", {63'h0, ifid_valid}, 64'h0);
    chk("boot_pc", imem_addr, 64'h0);
    repeat (3) cycle(1, 0, 0, 0);
    chk("seq_ifid_pc", ifid_pc, 64'h8);
    chk("seq_instr", {32'h0, ifid_instr}, {32'h0, hash_word(64'h8)});
    chk("seq_count", {32'h0, fetch_count}, 64'd3);

    // Stall two cycles with ADDS in IF/ID.
    ovr_addr = 64'hC; ovr_data = {11'b10101011000, 21'h01234};
    cycle(1, 0, 0, 0);
    repeat (2) begin
      cycle(1, 1, 0, 0);
      chk("stall_opcode", {53'h0, opcode}, {53'h0, 11'b10101011000});
      chk("stall_ifid_pc", ifid_pc, 64'hC);
      chk("stall_pc", imem_addr, 64'h10);
    end
    cycle(1, 0, 0, 0);
    chk("resume_ifid_pc", ifid_pc, 64'h10);
    chk("resume_count", {32'h0, fetch_count}, 64'd5);

    // Redirect overriding a stall in the same cycle.
    cycle(1, 1, 1, 64'h40);
    chk("redir_pc", imem_addr, 64'h40);
    chk("redir_valid", {63'h0, ifid_valid}, 64'h0);
    chk("redir_opcode", {53'h0, opcode}, 64'h0);
    cycle(1, 0, 0, 0);
    chk("redir_ifid_pc", ifid_pc, 64'h40);

    // HALT at 0x10, stall ignored while halted, branch out to 0x20.
    ovr_addr = 64'h10; ovr_data = 32'hFFFF_FFFF;
    cycle(1, 0, 1, 64'h10);
    cycle(1, 0, 0, 0);
    chk("halt_flag", {63'h0, halted}, 64'h1);
    repeat (5) begin
      cycle(1, bit'($urandom_range(0, 1)), 0, 0);
      chk("halt_pc", imem_addr, 64'h10);
      chk("halt_valid", {63'h0, ifid_valid}, 64'h0);
    end
    cycle(1, 1, 1, 64'h20);
    chk("unhalt_flag", {63'h0, halted}, 64'h0);
    cycle(1, 0, 0, 0);
    chk("unhalt_ifid_pc", ifid_pc, 64'h20);
    ovr_addr = 64'h1;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 63) != 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0),
            64'h1000 + 64'($urandom_range(0, 1023)) * 64'd4);
    end

    // PC wrap on the second instance.
    cycle(1, 1, 0, 0);
    chk("wrap_reset_pc", imem_addr_w, 64'hFFFF_FFFF_FFFF_FFFC);
    rst_w = 1'b1;
    cycle(1, 1, 0, 0);
    chk("wrap_boot_pc", imem_addr_w, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(1, 1, 0, 0);
    chk("wrap_ifid_pc", ifid_pc_w, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_pc0", imem_addr_w, 64'h0);
    cycle(1, 1, 0, 0);
    chk("wrap_ifid_pc0", ifid_pc_w, 64'h0);
    chk("wrap_count", {32'h0, fetch_count_w}, 64'd2);

    // Reset mid-operation during stall + redirect.
    repeat (3) cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 64'h80);
    chk("midrst_pc", imem_addr, 64'h0);
    chk("midrst_count", {32'h0, fetch_count}, 64'h0);
    chk("midrst_halted", {63'h0, halted}, 64'h0);
    cycle(1, 0, 1, 64'h80);
    chk("midrst_boot_valid", {63'h0, ifid_valid}, 64'h0);
    chk("midrst_boot_pc", imem_addr, 64'h0);
    cycle(1, 0, 0, 0);
    chk("midrst_first", ifid_pc, 64'h0);
    chk("midrst_first_valid", {63'h0, ifid_valid}, 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
